// File: rtl/alu_pkg.sv
// Shared types and helpers for seq_param_alu.
// hex7seg is only referenced when SEG7_EN is defined.
package alu_pkg;

  // Opcode values; 10..15 are illegal
  typedef enum logic [3:0] {
    OpAdd = 4'd0,
    OpSub = 4'd1,
    OpMul = 4'd2,
    OpDiv = 4'd3,
    OpMod = 4'd4,
    OpAnd = 4'd5,
    OpOr  = 4'd6,
    OpXor = 4'd7,
    OpShl = 4'd8,
    OpShr = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StDivide,
    StDone
  } state_e;

  // Bit positions inside flags = {Nf, Zf, C, V}
  localparam int unsigned FlagNeg   = 3;
  localparam int unsigned FlagZero  = 2;
  localparam int unsigned FlagCarry = 1;
  localparam int unsigned FlagOvf   = 0;

  // Hex digit to active-low segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7seg(input logic [3:0] digit);
    logic [6:0] seg;
    unique case (digit)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider: N quotient bits, one per clock.
// The first step is taken on the start edge itself, so done rises N-1 edges later.
// A zero divisor yields quotient all-ones and remainder equal to the dividend.
module alu_divider #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         done,
  output logic         div_zero
);

  localparam int unsigned CntW = $clog2(N);

  logic [N-1:0]    rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;

  logic [N-1:0] step_rem_in, step_quo_in, step_dvs, step_rem, step_quo;
  logic [N:0]   shifted, trial;

  // One restoring step; on start it works on fresh operands
  always_comb begin
    step_rem_in = start ? '0 : rem_q;
    step_quo_in = start ? dividend : quo_q;
    step_dvs    = start ? divisor : dvs_q;
    shifted     = {step_rem_in, step_quo_in[N-1]};
    trial       = shifted - {1'b0, step_dvs};
    if (shifted >= {1'b0, step_dvs}) begin
      step_rem = trial[N-1:0];
      step_quo = {step_quo_in[N-2:0], 1'b1};
    end else begin
      step_rem = shifted[N-1:0];
      step_quo = {step_quo_in[N-2:0], 1'b0};
    end
  end

  // Next-state: load and step on start, then step until the count runs out
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      rem_d  = step_rem;
      quo_d  = step_quo;
      dvs_d  = divisor;
      cnt_d  = CntW'(N - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  // State registers, cleared by reset even mid-divide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = busy_q && (cnt_q == '0);
  assign div_zero  = (dvs_q == '0);

endmodule

// File: rtl/seq_param_alu.sv
// Sequential N-bit ALU with valid/ready handshake on both sides.
// Single-cycle ops are evaluated from the inputs in the accept cycle; DIV/MOD use alu_divider.
// Optional macro SEG7_EN adds the seg_hex port driven from the result register.
module seq_param_alu
  import alu_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [N-1:0] Z,
  input  logic [N-1:0] Y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   flags,
  output logic         err
`ifdef SEG7_EN
  ,
  output logic [7*((N+3)/4)-1:0] seg_hex
`endif
);

  localparam logic [N:0] NVal = (N + 1)'(N);

  state_e       state_q, state_d;
  logic [3:0]   op_q, op_d;
  logic [N-1:0] result_q, result_d;
  logic [3:0]   flags_q, flags_d;
  logic         err_q, err_d;

  logic         div_start, div_done, div_zero;
  logic [N-1:0] div_quo, div_rem, div_res;

  logic [N:0]     sum, dif;
  logic [2*N-1:0] prod;
  logic [N-1:0]   alu_res;
  logic           alu_c, alu_v, alu_err;

  function automatic logic [3:0] pack_flags(input logic [N-1:0] r, input logic c,
                                            input logic v);
    logic [3:0] f;
    f            = '0;
    f[FlagNeg]   = r[N-1];
    f[FlagZero]  = (r == '0);
    f[FlagCarry] = c;
    f[FlagOvf]   = v;
    return f;
  endfunction

  alu_divider #(
    .N(N)
  ) u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (Z),
    .divisor  (Y),
    .quotient (div_quo),
    .remainder(div_rem),
    .done     (div_done),
    .div_zero (div_zero)
  );

  // Single-cycle datapath evaluated on the live inputs
  always_comb begin
    sum     = {1'b0, Z} + {1'b0, Y};
    dif     = {1'b0, Z} - {1'b0, Y};
    prod    = (2 * N)'(Z) * (2 * N)'(Y);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op)
      OpAdd: begin
        alu_res = sum[N-1:0];
        alu_c   = sum[N];
        alu_v   = (Z[N-1] == Y[N-1]) && (sum[N-1] != Z[N-1]);
      end
      OpSub: begin
        alu_res = dif[N-1:0];
        alu_c   = dif[N];  // borrow, i.e. Z < Y
        alu_v   = (Z[N-1] != Y[N-1]) && (dif[N-1] != Z[N-1]);
      end
      OpMul: begin
        alu_res = prod[N-1:0];
        alu_c   = |prod[2*N-1:N];
      end
      OpAnd: alu_res = Z & Y;
      OpOr:  alu_res = Z | Y;
      OpXor: alu_res = Z ^ Y;
      OpShl: alu_res = ({1'b0, Y} >= NVal) ? '0 : (Z << Y);
      OpShr: alu_res = ({1'b0, Y} >= NVal) ? '0 : (Z >> Y);
      OpDiv, OpMod: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  assign div_res = (op_q == OpDiv) ? div_quo : div_rem;

  // FSM next-state; result registers load only on entry to StDone
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    result_d  = result_q;
    flags_d   = flags_q;
    err_d     = err_q;
    div_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d = op;
          if (op == OpDiv || op == OpMod) begin
            div_start = 1'b1;
            state_d   = StDivide;
          end else begin
            state_d  = StDone;
            result_d = alu_res;
            flags_d  = alu_err ? 4'b0000 : pack_flags(alu_res, alu_c, alu_v);
            err_d    = alu_err;
          end
        end
      end
      StDivide: begin
        if (div_done) begin
          state_d  = StDone;
          result_d = div_res;
          flags_d  = pack_flags(div_res, 1'b0, 1'b0);
          err_d    = div_zero;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign flags     = flags_q;
  assign err       = err_q;

`ifdef SEG7_EN
  localparam int unsigned Digits = (N + 3) / 4;

  logic [4*Digits-1:0] res_pad;

  // Zero-extend the result to whole hex digits
  always_comb begin
    res_pad        = '0;
    res_pad[N-1:0] = result_q;
  end

  for (genvar i = 0; i < Digits; i++) begin : g_seg
    assign seg_hex[7*i +: 7] = hex7seg(res_pad[4*i +: 4]);
  end
`endif

endmodule
